// File: rtl/pipe_chain.sv
// rtl/pipe_chain.sv - parametrised pipeline-register chain with valid bits, stall and flush
//
// Purpose: DEPTH-stage staging chain (stage 0 = PC ... stage DEPTH-1 = MW).
//   Each stage holds a valid bit and WIDTH data bits. Data is shifted left by
//   SHIFT on every stage-to-stage move and again at the output.
// Ports:
//   clk        rising-edge clock
//   clr_n      asynchronous active-low reset
//   en         global enable; 0 freezes all state and drops in_ready
//   in_valid   entry offered to stage 0
//   in_data    entry payload
//   in_ready   stage 0 loads this cycle (en & no stall at or after stage 0)
//   stall      stall[i] holds stage i and every upstream stage
//   flush      flush[i] turns stage i's next value into a bubble
//   out_valid  valid bit of the last stage
//   q          last-stage data shifted left by SHIFT
//   occ        registered count of valid stages
module pipe_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5,
  parameter int SHIFT = 1
) (
  input  logic                         clk,
  input  logic                         clr_n,
  input  logic                         en,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  input  logic [DEPTH-1:0]             stall,
  input  logic [DEPTH-1:0]             flush,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             q,
  output logic [$clog2(DEPTH+1)-1:0]   occ
);

  localparam int OW = $clog2(DEPTH+1);

  logic [DEPTH-1:0]            v;
  logic [DEPTH-1:0][WIDTH-1:0] d;
  logic [DEPTH-1:0]            hold;
  logic [DEPTH-1:0]            v_nxt;
  logic [DEPTH-1:0][WIDTH-1:0] d_nxt;
  logic [OW-1:0]               occ_nxt;

  // hold[i] is the OR of stall[j] for j >= i, built from the top stage down.
  always_comb begin
    logic acc;
    acc  = 1'b0;
    hold = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      acc     = acc | stall[i];
      hold[i] = acc;
    end
  end

  always_comb begin
    v_nxt = v;
    d_nxt = d;

    // Stage 0 loads straight from the input, unshifted.
    if (flush[0]) begin
      v_nxt[0] = 1'b0;
      d_nxt[0] = '0;
    end else if (!hold[0]) begin
      v_nxt[0] = in_valid;
      d_nxt[0] = in_data;
    end

    // A stalled upstream stage hands a bubble forward; its data still moves
    // but is meaningless because the valid bit is cleared.
    for (int i = 1; i < DEPTH; i++) begin
      if (flush[i]) begin
        v_nxt[i] = 1'b0;
        d_nxt[i] = '0;
      end else if (!hold[i]) begin
        v_nxt[i] = v[i-1] & ~hold[i-1];
        d_nxt[i] = d[i-1] << SHIFT;
      end
    end
  end

  // occ tracks the popcount of the valid bits that will be registered.
  always_comb begin
    occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_nxt = occ_nxt + OW'(v_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      v   <= '0;
      d   <= '0;
      occ <= '0;
    end else if (en) begin
      v   <= v_nxt;
      d   <= d_nxt;
      occ <= occ_nxt;
    end
  end

  assign in_ready  = en & ~hold[0];
  assign out_valid = v[DEPTH-1];
  assign q         = d[DEPTH-1] << SHIFT;

endmodule

// File: tb/tb_pipe_chain.sv
// tb/tb_pipe_chain.sv - scoreboard bench for pipe_chain (SHIFT=1 and SHIFT=0 builds)
module tb_pipe_chain;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        en;
  logic        in_valid;
  logic [31:0] in_data;
  logic [4:0]  stall;
  logic [4:0]  flush;

  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [31:0] q0, q1;
  logic [2:0]  occ0, occ1;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp0[$];
  logic [31:0] exp1[$];

  always #5 clk = ~clk;

  pipe_chain #(.WIDTH(32), .DEPTH(5), .SHIFT(1)) dut0 (
    .clk(clk), .clr_n(clr_n), .en(en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .stall(stall), .flush(flush),
    .out_valid(out_valid0), .q(q0), .occ(occ0)
  );

  pipe_chain #(.WIDTH(32), .DEPTH(5), .SHIFT(0)) dut1 (
    .clk(clk), .clr_n(clr_n), .en(en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .stall(stall), .flush(flush),
    .out_valid(out_valid1), .q(q1), .occ(occ1)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: an output is consumed only when it will actually leave the last
  // stage on the coming edge (enabled, not stalled), so a held q counts once.
  always @(negedge clk) begin
    if (clr_n === 1'b1 && en && !stall[4]) begin
      if (out_valid0) begin
        if (exp0.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_q0: got 0x%0h expected none", q0);
        end else check("q_shift1", q0, exp0.pop_front());
      end
      if (out_valid1) begin
        if (exp1.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_q1: got 0x%0h expected none", q1);
        end else check("q_shift0", q1, exp1.pop_front());
      end
    end
  end

  // Drive one cycle of inputs starting just after a rising edge.
  task automatic step(input logic v, input logic [31:0] dat, input logic [4:0] st,
                      input logic [4:0] fl, input logic e);
    logic rdy;
    in_valid = v; in_data = dat; stall = st; flush = fl; en = e;
    rdy = e && (st == 5'b0);
    #1;
    check("in_ready", {31'b0, in_ready0}, {31'b0, rdy});
    if (v && rdy && !fl[0]) begin
      exp0.push_back(dat << 5);
      exp1.push_back(dat);
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] dat);
    step(1'b1, dat, 5'b0, 5'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, 5'b0, 5'b0, 1'b1);
  endtask

  initial begin
    clr_n = 1'b0; en = 1'b1; in_valid = 1'b0; in_data = '0; stall = '0; flush = '0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_out_valid", {31'b0, out_valid0}, 32'h0);
    check("rst_q", q0, 32'h0);
    check("rst_occ", {29'b0, occ0}, 32'h0);
    check("rst_in_ready", {31'b0, in_ready0}, 32'h1);
    clr_n = 1'b1;

    // Single entry: occ 1 for five edges, out after edge 5, empty after edge 6.
    send(32'h1);
    check("single_occ", {29'b0, occ0}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      check("single_occ", {29'b0, occ0}, 32'd1);
    end
    check("single_out_valid", {31'b0, out_valid0}, 32'h1);
    check("single_q", q0, 32'h20);
    idle(1);
    check("single_occ_end", {29'b0, occ0}, 32'd0);

    // Streaming 1..8: occ saturates at 5.
    for (int n = 1; n <= 8; n++) send(32'(n));
    check("stream_occ", {29'b0, occ0}, 32'd5);
    idle(6);
    check("stream_drain_occ", {29'b0, occ0}, 32'd0);

    // Stall stage 2 for two cycles with four entries in flight.
    for (int n = 9; n <= 12; n++) send(32'(n));
    check("stall_pre_occ", {29'b0, occ0}, 32'd4);
    step(1'b1, 32'd13, 5'b00100, 5'b0, 1'b1);
    check("stall1_occ", {29'b0, occ0}, 32'd4);
    step(1'b1, 32'd13, 5'b00100, 5'b0, 1'b1);
    check("stall2_occ", {29'b0, occ0}, 32'd3);
    check("stall2_out_valid", {31'b0, out_valid0}, 32'h0);
    for (int n = 13; n <= 16; n++) send(32'(n));
    idle(6);

    // Flush stages 0-1 with a full pipe: the entry leaving stage 0 (24) and
    // the offered 25 are lost; 23 still advances into stage 2.
    for (int n = 20; n <= 24; n++) send(32'(n));
    check("flush_pre_occ", {29'b0, occ0}, 32'd5);
    step(1'b1, 32'd25, 5'b0, 5'b00011, 1'b1);
    void'(exp0.pop_back());
    void'(exp1.pop_back());
    check("flush_occ", {29'b0, occ0}, 32'd3);
    idle(6);

    // MSB truncation through the shifts.
    send(32'h8000_0001);
    idle(6);

    // en=0 freezes everything and ignores stall/flush.
    for (int n = 30; n <= 32; n++) send(32'(n));
    check("en_pre_occ", {29'b0, occ0}, 32'd3);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 32'd99, 5'b11111, 5'b11111, 1'b0);
      check("en0_occ", {29'b0, occ0}, 32'd3);
    end
    idle(6);
    check("en_drain_occ", {29'b0, occ0}, 32'd0);

    // Asynchronous reset with a full pipe.
    for (int n = 40; n <= 44; n++) send(32'(n));
    check("rst_mid_pre_occ", {29'b0, occ0}, 32'd5);
    check("rst_mid_pre_valid", {31'b0, out_valid0}, 32'h1);
    #1 clr_n = 1'b0;
    #1;
    check("rst_mid_out_valid", {31'b0, out_valid0}, 32'h0);
    check("rst_mid_q", q0, 32'h0);
    check("rst_mid_occ", {29'b0, occ0}, 32'd0);
    check("rst_mid_in_ready", {31'b0, in_ready0}, 32'h1);
    exp0.delete();
    exp1.delete();
    @(posedge clk); #1;
    clr_n = 1'b1;
    send(32'd50);
    idle(6);

    check("final_exp0_empty", 32'(exp0.size()), 32'd0);
    check("final_exp1_empty", 32'(exp1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
